lvds_host_ctrl: RTL and testbench

Host-side command sequencer that sits directly upstream of `lvds_host`. It buffers read/write commands from local logic in a 4-entry FIFO and formats each one into the 40-bit `wdata` word with a one-cycle `wvalid` strobe. Every frame sent to the target produces exactly one return frame, so the block keeps one transaction in flight. After a fixed response delay it samples `lvds_host.rdata` and presents the result on a valid/ready response port.

---
 rtl/lvds_host_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_lvds_host_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_host_ctrl.sv
// lvds_host_ctrl
//   Host-side command sequencer for lvds_host. Local commands are queued in a
//   4-entry FIFO, formatted into a 40-bit frame with a single-cycle wvalid
//   strobe, and after a fixed response delay the returned rdata is captured
//   and offered on a valid/ready response port. One transaction in flight.
//
// Ports
//   c            clock (same as lvds_host.c)
//   r            synchronous active-low reset
//   cmd_valid    command offered
//   cmd_ready    FIFO can accept (not full and not in reset)
//   cmd_write    1 = write, 0 = read
//   cmd_addr     register address, bit 7 reserved (dropped from the frame)
//   cmd_wdata    write data, ignored for reads
//   resp_valid   response available
//   resp_ready   response consumed
//   resp_write   write flag of the command this response belongs to
//   resp_rdata   rdata captured at the end of the response wait
//   wvalid       single-cycle frame strobe to lvds_host
//   wdata        frame {write, addr[6:0], data}, meaningful only with wvalid
//   rdata        readback word from lvds_host (unqualified)
//   busy         transaction active or commands queued
module lvds_host_ctrl #(
    parameter int RESP_WAIT = 300
) (
    input  logic        c,
    input  logic        r,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_write,
    output logic [31:0] resp_rdata,
    output logic        wvalid,
    output logic [39:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy
);

    // wvalid is registered out of SEND, so counting down from RESP_WAIT-1
    // places the capture edge exactly RESP_WAIT edges after wvalid rises.
    localparam logic [15:0] CNT_LOAD = 16'(RESP_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [40:0] r_fifo [4];
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_count;
    logic [40:0] r_cmd;
    logic [15:0] r_cnt;
    logic        r_wvalid;
    logic [39:0] r_wdata;
    logic        r_resp_valid;
    logic        r_resp_write;
    logic [31:0] r_resp_rdata;

    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_send;
    logic        w_capture;
    logic        w_done;
    logic        w_unused_addr7;

    assign w_full         = (r_count == 3'd4);
    assign cmd_ready      = !w_full && r;
    assign w_push         = cmd_valid && cmd_ready;
    // Reserved address bit travels through the FIFO but never reaches the frame.
    assign w_unused_addr7 = r_cmd[39];

    // State register
    always_ff @(posedge c) begin
        if (!r) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_count != 3'd0) w_state_nxt = ST_SEND;
            ST_SEND: w_state_nxt = ST_WAIT;
            ST_WAIT: if (r_cnt == 16'd0) w_state_nxt = ST_RESP;
            ST_RESP: if (r_resp_valid && resp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_pop     = 1'b0;
        w_send    = 1'b0;
        w_capture = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            ST_IDLE: w_pop     = (r_count != 3'd0);
            ST_SEND: w_send    = 1'b1;
            ST_WAIT: w_capture = (r_cnt == 16'd0);
            ST_RESP: w_done    = r_resp_valid && resp_ready;
            default: ;
        endcase
    end

    // FIFO storage; entries are only meaningful while counted, so no reset
    always_ff @(posedge c) begin
        if (w_push) begin
            r_fifo[r_wptr] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge c) begin
        if (!r) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 2'd1;
            if (w_pop)  r_rptr <= r_rptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: ;
            endcase
        end
    end

    // Command held for the whole transaction
    always_ff @(posedge c) begin
        if (!r) begin
            r_cmd <= '0;
        end else if (w_pop) begin
            r_cmd <= r_fifo[r_rptr];
        end
    end

    // Frame strobe and response-wait counter
    always_ff @(posedge c) begin
        if (!r) begin
            r_wvalid <= 1'b0;
            r_wdata  <= '0;
            r_cnt    <= '0;
        end else begin
            r_wvalid <= w_send;
            if (w_send) begin
                // Reads carry a zero payload.
                r_wdata <= {r_cmd[40], r_cmd[38:32], r_cmd[40] ? r_cmd[31:0] : 32'd0};
                r_cnt   <= CNT_LOAD;
            end else if (r_state == ST_WAIT && r_cnt != 16'd0) begin
                r_cnt <= r_cnt - 16'd1;
            end
        end
    end

    // Response capture and handshake
    always_ff @(posedge c) begin
        if (!r) begin
            r_resp_valid <= 1'b0;
            r_resp_write <= 1'b0;
            r_resp_rdata <= '0;
        end else if (w_capture) begin
            r_resp_valid <= 1'b1;
            r_resp_write <= r_cmd[40];
            r_resp_rdata <= rdata;
        end else if (w_done) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign wvalid     = r_wvalid;
    assign wdata      = r_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_write = r_resp_write;
    assign resp_rdata = r_resp_rdata;
    assign busy       = (r_state != ST_IDLE) || (r_count != 3'd0);

endmodule

// File: tb/tb_lvds_host_ctrl.sv
// tb_lvds_host_ctrl
//   Self-checking bench for lvds_host_ctrl. Instance A uses the default
//   response wait (300); instance B uses the minimum wait (16). Expected
//   frames and responses come from a command queue model and a record of the
//   rdata value present on every clock edge.
`timescale 1ns/1ps
module tb_lvds_host_ctrl;
    localparam int RW   = 300;
    localparam int RW_B = 16;
    localparam int HIST = 32768;

    logic        c = 1'b0;
    logic        r = 1'b0;

    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr  = 8'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        resp_ready = 1'b0;
    logic [31:0] rdata_a = 32'd0;
    logic        cmd_ready, resp_valid, resp_write, wvalid, busy;
    logic [31:0] resp_rdata;
    logic [39:0] wdata;

    logic        b_cmd_valid = 1'b0;
    logic [31:0] rdata_b = 32'd0;
    logic        b_cmd_ready, b_resp_valid, b_resp_write, b_wvalid, b_busy;
    logic [31:0] b_resp_rdata;
    logic [39:0] b_wdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rd_rand = 1'b1;
    bit rr_rand = 1'b0;

    // Observation records
    int          wv_edge_q[$];
    logic [39:0] wv_data_q[$];
    int          rv_edge_q[$];
    logic [31:0] rv_data_q[$];
    logic        rv_write_q[$];
    logic [31:0] rd_hist  [HIST];
    logic [31:0] rdb_hist [HIST];
    int          hs_cnt = 0;
    logic        prev_rv = 1'b0;

    // Reference model: commands accepted, in order
    logic        exp_w_q[$];
    logic [7:0]  exp_a_q[$];
    logic [31:0] exp_d_q[$];

    lvds_host_ctrl #(.RESP_WAIT(RW)) u_dut (
        .c(c), .r(r),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_rdata(resp_rdata), .wvalid(wvalid), .wdata(wdata),
        .rdata(rdata_a), .busy(busy)
    );

    lvds_host_ctrl #(.RESP_WAIT(RW_B)) u_dut_b (
        .c(c), .r(r),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(1'b0),
        .cmd_addr(8'h33), .cmd_wdata(32'h0),
        .resp_valid(b_resp_valid), .resp_ready(1'b1), .resp_write(b_resp_write),
        .resp_rdata(b_resp_rdata), .wvalid(b_wvalid), .wdata(b_wdata),
        .rdata(rdata_b), .busy(b_busy)
    );

    always #2.5 c = ~c;

    always @(posedge c) cyc <= cyc + 1;

    // Recorder: everything is sampled 1 ns after the edge and tagged with the
    // edge index; input values at that point are the ones the edge saw.
    always @(posedge c) begin
        #1;
        if (cyc < HIST) begin
            rd_hist[cyc]  <= rdata_a;
            rdb_hist[cyc] <= rdata_b;
        end
        if (wvalid) begin
            wv_edge_q.push_back(cyc);
            wv_data_q.push_back(wdata);
        end
        if (resp_valid && !prev_rv) begin
            rv_edge_q.push_back(cyc);
            rv_data_q.push_back(resp_rdata);
            rv_write_q.push_back(resp_write);
        end
        if (prev_rv && resp_ready && r) hs_cnt <= hs_cnt + 1;
        prev_rv <= resp_valid;
    end

    initial forever begin
        @(negedge c);
        if (rd_rand) rdata_a = $urandom;
        rdata_b = 32'(cyc);
    end

    initial forever begin
        @(negedge c);
        if (rr_rand) resp_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #250000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one command starting at a negedge; returns at the negedge after acceptance.
    task automatic push_cmd(input logic w, input logic [7:0] a, input logic [31:0] d,
                            output int acc);
        int n;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 4000) begin @(negedge c); n++; end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout cmd_ready=%b required 1", cmd_ready);
            acc = -1;
            cmd_valid = 1'b0;
            return;
        end
        @(posedge c); #1;
        acc = cyc;
        exp_w_q.push_back(w); exp_a_q.push_back(a); exp_d_q.push_back(d);
        @(negedge c);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        r = 1'b0;
        repeat (3) @(negedge c);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); end
        checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL rst_wvalid got %b want 0", wvalid); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (wdata !== 40'd0) begin errors++; $display("FAIL rst_wdata got %h want 0", wdata); end
        checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL rst_resp_rdata got %h want 0", resp_rdata); end
        checks++; if (resp_write !== 1'b0) begin errors++; $display("FAIL rst_resp_write got %b want 0", resp_write); end
        r = 1'b1;
        @(negedge c);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_cmd_ready got %b want 1", cmd_ready); end
    endtask

    task automatic test_single_write();
        int acc, wb, rb, hb;
        exp_w_q.delete(); exp_a_q.delete(); exp_d_q.delete();
        rd_rand = 1'b0; rdata_a = 32'hCAFEF00D; resp_ready = 1'b1;
        wb = wv_edge_q.size(); rb = rv_edge_q.size(); hb = hs_cnt;
        push_cmd(1'b1, 8'h12, 32'hDEADBEEF, acc);
        for (int i = 0; i < RW + 50 && hs_cnt < hb + 1; i++) @(negedge c);
        checks++; if (hs_cnt < hb + 1) begin errors++; $display("FAIL wr_timeout handshakes %0d want %0d", hs_cnt - hb, 1); end
        checks++; if (wv_edge_q.size() != wb + 1) begin errors++; $display("FAIL wr_strobe_cycles got %0d want 1", wv_edge_q.size() - wb); end
        checks++; if (wv_edge_q[wb] != acc + 2) begin errors++; $display("FAIL wr_latency got %0d want %0d", wv_edge_q[wb] - acc, 2); end
        checks++; if (wv_data_q[wb] !== 40'h92DEADBEEF) begin errors++; $display("FAIL wr_wdata got %h want 92deadbeef", wv_data_q[wb]); end
        checks++; if (rv_edge_q[rb] - wv_edge_q[wb] != RW) begin errors++; $display("FAIL wr_resp_delay got %0d want %0d", rv_edge_q[rb] - wv_edge_q[wb], RW); end
        checks++; if (rv_data_q[rb] !== 32'hCAFEF00D) begin errors++; $display("FAIL wr_resp_rdata got %h want cafef00d", rv_data_q[rb]); end
        checks++; if (rv_write_q[rb] !== 1'b1) begin errors++; $display("FAIL wr_resp_write got %b want 1", rv_write_q[rb]); end
        rd_rand = 1'b1;
        exp_w_q.delete(); exp_a_q.delete(); exp_d_q.delete();
    endtask

    task automatic test_single_read();
        int acc, wb, rb, hb;
        resp_ready = 1'b1;
        wb = wv_edge_q.size(); rb = rv_edge_q.size(); hb = hs_cnt;
        push_cmd(1'b0, 8'h05, $urandom, acc);
        for (int i = 0; i < RW + 50 && hs_cnt < hb + 1; i++) @(negedge c);
        checks++; if (hs_cnt < hb + 1) begin errors++; $display("FAIL rd_timeout handshakes %0d want 1", hs_cnt - hb); end
        checks++; if (wv_data_q[wb] !== 40'h0500000000) begin errors++; $display("FAIL rd_wdata got %h want 0500000000", wv_data_q[wb]); end
        checks++; if (rv_edge_q[rb] - wv_edge_q[wb] != RW) begin errors++; $display("FAIL rd_resp_delay got %0d want %0d", rv_edge_q[rb] - wv_edge_q[wb], RW); end
        checks++; if (rv_data_q[rb] !== rd_hist[rv_edge_q[rb]]) begin errors++; $display("FAIL rd_resp_rdata got %h want %h", rv_data_q[rb], rd_hist[rv_edge_q[rb]]); end
        checks++; if (rv_write_q[rb] !== 1'b0) begin errors++; $display("FAIL rd_resp_write got %b want 0", rv_write_q[rb]); end
        repeat (3) @(negedge c);
        checks++; if (resp_rdata !== rv_data_q[rb]) begin errors++; $display("FAIL rd_rdata_hold got %h want %h", resp_rdata, rv_data_q[rb]); end
        exp_w_q.delete(); exp_a_q.delete(); exp_d_q.delete();
    endtask

    task automatic test_backpressure();
        int acc, wb, rb, hb, bad;
        logic [31:0] v;
        resp_ready = 1'b0;
        wb = wv_edge_q.size(); rb = rv_edge_q.size(); hb = hs_cnt;
        push_cmd(1'b1, {1'b0, 7'($urandom)}, $urandom, acc);
        for (int i = 0; i < RW + 50 && rv_edge_q.size() <= rb; i++) @(negedge c);
        checks++; if (rv_edge_q.size() <= rb) begin errors++; $display("FAIL bp_timeout resp_valid=%b want 1", resp_valid); end
        v = resp_rdata;
        checks++; if (v !== rd_hist[rv_edge_q[rb]]) begin errors++; $display("FAIL bp_rdata got %h want %h", v, rd_hist[rv_edge_q[rb]]); end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge c);
            if (resp_valid !== 1'b1 || resp_rdata !== v || wvalid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable unstable_cycles %0d want 0", bad); end
        checks++; if (wv_edge_q.size() != wb + 1) begin errors++; $display("FAIL bp_no_new_frame frames %0d want 1", wv_edge_q.size() - wb); end
        resp_ready = 1'b1;
        @(negedge c);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_handshake resp_valid=%b want 0", resp_valid); end
        checks++; if (hs_cnt != hb + 1) begin errors++; $display("FAIL bp_hs_count got %0d want 1", hs_cnt - hb); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle busy=%b want 0", busy); end
        exp_w_q.delete(); exp_a_q.delete(); exp_d_q.delete();
    endtask

    task automatic test_burst();
        int acc, acc0, wb, rb, hb, bad;
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [39:0] fr;
        exp_w_q.delete(); exp_a_q.delete(); exp_d_q.delete();
        resp_ready = 1'b0;
        wb = wv_edge_q.size(); rb = rv_edge_q.size(); hb = hs_cnt;
        acc0 = 0;
        for (int i = 0; i < 5; i++) begin
            push_cmd(1'($urandom), {1'b0, 7'($urandom)}, $urandom, acc);
            if (i == 0) acc0 = acc;
        end
        checks++; if (acc - acc0 != 4) begin errors++; $display("FAIL burst_b2b accept_span %0d want 4", acc - acc0); end
        w = 1'($urandom); a = {1'b0, 7'($urandom)}; d = $urandom;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL burst_full cmd_ready=%b want 0", cmd_ready); end
        bad = 0;
        for (int i = 0; i < RW + 20; i++) begin
            @(negedge c);
            if (cmd_ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL burst_hold_full ready_cycles %0d want 0", bad); end
        resp_ready = 1'b1;
        push_cmd(w, a, d, acc);
        for (int i = 0; i < 6 * (RW + 10) + 100 && hs_cnt < hb + 6; i++) @(negedge c);
        checks++; if (hs_cnt < hb + 6) begin errors++; $display("FAIL burst_timeout handshakes %0d want 6", hs_cnt - hb); end
        checks++; if (rv_edge_q.size() != rb + 6) begin errors++; $display("FAIL burst_resp_count got %0d want 6", rv_edge_q.size() - rb); end
        for (int i = 0; i < 6; i++) begin
            w = exp_w_q.pop_front(); a = exp_a_q.pop_front(); d = exp_d_q.pop_front();
            fr = {w, a[6:0], (w ? d : 32'd0)};
            checks++; if (wv_data_q[wb+i] !== fr) begin errors++; $display("FAIL burst_wdata[%0d] got %h want %h", i, wv_data_q[wb+i], fr); end
            checks++; if (rv_edge_q[rb+i] - wv_edge_q[wb+i] != RW) begin errors++; $display("FAIL burst_delay[%0d] got %0d want %0d", i, rv_edge_q[rb+i] - wv_edge_q[wb+i], RW); end
            checks++; if (rv_data_q[rb+i] !== rd_hist[rv_edge_q[rb+i]]) begin errors++; $display("FAIL burst_rdata[%0d] got %h want %h", i, rv_data_q[rb+i], rd_hist[rv_edge_q[rb+i]]); end
            checks++; if (rv_write_q[rb+i] !== w) begin errors++; $display("FAIL burst_write[%0d] got %b want %b", i, rv_write_q[rb+i], w); end
            if (i > 0) begin
                checks++; if (wv_edge_q[wb+i] - wv_edge_q[wb+i-1] < RW + 2) begin errors++; $display("FAIL burst_spacing[%0d] got %0d want >=%0d", i, wv_edge_q[wb+i] - wv_edge_q[wb+i-1], RW + 2); end
            end
        end
    endtask

    task automatic test_random();
        int acc, wb, rb, hb;
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [39:0] fr;
        exp_w_q.delete(); exp_a_q.delete(); exp_d_q.delete();
        wb = wv_edge_q.size(); rb = rv_edge_q.size(); hb = hs_cnt;
        rr_rand = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom);
            if (i == 0) a[7] = 1'b1;
            push_cmd(1'($urandom), a, $urandom, acc);
            repeat ($urandom_range(0, 3)) @(negedge c);
        end
        for (int i = 0; i < 8 * (RW + 40) + 200 && hs_cnt < hb + 8; i++) @(negedge c);
        rr_rand = 1'b0;
        resp_ready = 1'b1;
        @(negedge c);
        checks++; if (hs_cnt < hb + 8) begin errors++; $display("FAIL rand_timeout handshakes %0d want 8", hs_cnt - hb); end
        for (int i = 0; i < 8; i++) begin
            w = exp_w_q.pop_front(); a = exp_a_q.pop_front(); d = exp_d_q.pop_front();
            fr = {w, a[6:0], (w ? d : 32'd0)};
            checks++; if (wv_data_q[wb+i] !== fr) begin errors++; $display("FAIL rand_wdata[%0d] got %h want %h", i, wv_data_q[wb+i], fr); end
            checks++; if (rv_edge_q[rb+i] - wv_edge_q[wb+i] != RW) begin errors++; $display("FAIL rand_delay[%0d] got %0d want %0d", i, rv_edge_q[rb+i] - wv_edge_q[wb+i], RW); end
            checks++; if (rv_data_q[rb+i] !== rd_hist[rv_edge_q[rb+i]]) begin errors++; $display("FAIL rand_rdata[%0d] got %h want %h", i, rv_data_q[rb+i], rd_hist[rv_edge_q[rb+i]]); end
            checks++; if (rv_write_q[rb+i] !== w) begin errors++; $display("FAIL rand_write[%0d] got %b want %b", i, rv_write_q[rb+i], w); end
        end
    endtask

    task automatic test_reset_mid_wait();
        int acc, wb, rb, bad;
        exp_w_q.delete(); exp_a_q.delete(); exp_d_q.delete();
        resp_ready = 1'b1;
        push_cmd(1'b1, 8'h21, 32'hA5A5_0001 | $urandom, acc);
        for (int i = 0; i < 3; i++) push_cmd(1'($urandom), {1'b0, 7'($urandom)}, $urandom, acc);
        repeat (40) @(negedge c);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", busy); end
        wb = wv_edge_q.size(); rb = rv_edge_q.size();
        r = 1'b0;
        @(negedge c);
        checks++; if (wvalid !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl wvalid=%b resp_valid=%b busy=%b want 0 0 0", wvalid, resp_valid, busy); end
        checks++; if (wdata !== 40'd0) begin errors++; $display("FAIL mid_rst_wdata got %h want 0", wdata); end
        checks++; if (resp_rdata !== 32'd0 || resp_write !== 1'b0) begin errors++; $display("FAIL mid_rst_resp rdata=%h write=%b want 0 0", resp_rdata, resp_write); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_cmd_ready got %b want 0", cmd_ready); end
        r = 1'b1;
        @(negedge c);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_release_cmd_ready got %b want 1", cmd_ready); end
        bad = 0;
        for (int i = 0; i < 2 * RW; i++) begin
            @(negedge c);
            if (resp_valid !== 1'b0 || wvalid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_quiet active_cycles %0d want 0", bad); end
        checks++; if (rv_edge_q.size() != rb || wv_edge_q.size() != wb) begin errors++; $display("FAIL mid_discard resp %0d frames %0d want 0 0", rv_edge_q.size() - rb, wv_edge_q.size() - wb); end
        exp_w_q.delete(); exp_a_q.delete(); exp_d_q.delete();
    endtask

    task automatic test_short_wait();
        int wvb, rvb;
        logic [31:0] got;
        logic [39:0] fr;
        wvb = -1; rvb = -1; got = '0; fr = '0;
        b_cmd_valid = 1'b1;
        checks++; if (b_cmd_ready !== 1'b1) begin errors++; $display("FAIL short_cmd_ready got %b want 1", b_cmd_ready); end
        @(negedge c);
        b_cmd_valid = 1'b0;
        for (int i = 0; i < 80 && rvb < 0; i++) begin
            @(negedge c);
            if (b_wvalid && wvb < 0) begin wvb = cyc; fr = b_wdata; end
            if (b_resp_valid && rvb < 0) begin rvb = cyc; got = b_resp_rdata; end
        end
        checks++; if (wvb < 0 || rvb < 0) begin errors++; $display("FAIL short_timeout wvalid_edge %0d resp_edge %0d want both seen", wvb, rvb); end
        checks++; if (fr !== 40'h3300000000) begin errors++; $display("FAIL short_wdata got %h want 3300000000", fr); end
        checks++; if (rvb - wvb != RW_B) begin errors++; $display("FAIL short_delay got %0d want %0d", rvb - wvb, RW_B); end
        checks++; if (got !== rdb_hist[wvb + RW_B]) begin errors++; $display("FAIL short_rdata got %h want %h", got, rdb_hist[wvb + RW_B]); end
        checks++; if (b_resp_write !== 1'b0) begin errors++; $display("FAIL short_resp_write got %b want 0", b_resp_write); end
    endtask

    initial begin
        @(negedge c);
        test_reset();
        test_single_write();
        test_single_read();
        test_backpressure();
        test_burst();
        test_random();
        test_reset_mid_wait();
        test_short_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
